// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver.
// Latency: a byte written on edge N is visible on rd_data (empty=0) after edge N.
// Backpressure: none toward the receiver; a write into a full FIFO without a
// same-cycle pop is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wr_data, wr_valid   byte and one-cycle strobe from the receiver
//   rd_en               pop the head entry (ignored while empty)
//   flush               synchronous clear of contents and overflow
//   overflow_clr        clear the sticky overflow flag
//   rd_data             head entry, 0 when empty
//   empty, full, count  occupancy status, all from the registered count
//   overflow            sticky dropped-write flag
//   wm_level, wm_irq    watermark threshold and registered interrupt
//                       (present only when UART_RX_FIFO_WATERMARK_EN is defined)
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       overflow_clr,
`ifdef UART_RX_FIFO_WATERMARK_EN
  input  logic [$clog2(DEPTH):0]     wm_level,
  output logic                       wm_irq,
`endif
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_next;
  logic              overflow_q;

  logic              pop;
  logic              wr_ok;
  logic              drop;

  // Status comes straight from the registered count, so there is no
  // combinational path from rd_en/wr_valid to empty/full/count.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign overflow = overflow_q;

  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok = wr_valid && (!full || pop);
  assign drop  = wr_valid && full && !pop;

  // Post-update occupancy; flush forces zero so the watermark drops with it.
  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({wr_ok, pop})
        2'b10:   count_next = count_q + CW'(1);
        2'b01:   count_next = count_q - CW'(1);
        default: count_next = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_next;
      // A dropped write wins over a coincident clear.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage is not reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

`ifdef UART_RX_FIFO_WATERMARK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wm_irq <= 1'b0;
    end else begin
      wm_irq <= (wm_level != '0) && (count_next >= wm_level);
    end
  end
`endif

endmodule
